// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: configuration handshake and divided-clock outputs of clk_div_ctrl.
`default_nettype none

interface clk_div_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_en;
  logic [WIDTH-1:0] cfg_div;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [WIDTH-1:0] div_cur;

  modport master (
    output cfg_valid, cfg_en, cfg_div,
    input  cfg_ready, clk_out, tick, busy, div_cur
  );

  modport slave (
    input  cfg_valid, cfg_en, cfg_div,
    output cfg_ready, clk_out, tick, busy, div_cur
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// +------------------------------------------------------------------------+
// | clk_div_ctrl: programmable clock divider; start/stop/ratio changes     |
// | are applied only on output-period boundaries.                          |
// | Revision: 1.1                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module clk_div_ctrl #(
    parameter int WIDTH = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    clk_div_ctrl_if.slave cfg
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_PEND = 2'd2;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_TWO = WIDTH'(2);

    logic [1:0]       r_state, w_state_d;
    logic [WIDTH-1:0] r_cnt, w_cnt_d;
    logic             r_clk_out, w_clk_out_d;
    logic [WIDTH-1:0] r_div_cur, w_div_cur_d;
    logic [WIDTH-1:0] r_div_pend, w_div_pend_d;
    logic             r_en_pend, w_en_pend_d;

    logic             w_busy;
    logic             w_at_end;
    logic             w_wrap;
    logic             w_accept;
    logic [WIDTH-1:0] w_div_clamped;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_cnt_next;

    assign w_busy        = (r_state != c_IDLE);
    assign w_at_end      = (r_cnt == (r_div_cur - c_ONE));
    assign w_wrap        = w_busy && w_at_end;
    assign w_accept      = cfg.cfg_valid && (r_state != c_PEND);
    assign w_div_clamped = (cfg.cfg_div < c_TWO) ? c_TWO : cfg.cfg_div;
    assign w_half        = r_div_cur >> 1;
    assign w_cnt_next    = w_at_end ? '0 : (r_cnt + c_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_clk_out  <= 1'b0;
            r_div_cur  <= '0;
            r_div_pend <= '0;
            r_en_pend  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_clk_out  <= w_clk_out_d;
            r_div_cur  <= w_div_cur_d;
            r_div_pend <= w_div_pend_d;
            r_en_pend  <= w_en_pend_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_clk_out_d  = r_clk_out;
        w_div_cur_d  = r_div_cur;
        w_div_pend_d = r_div_pend;
        w_en_pend_d  = r_en_pend;

        case (r_state)
            c_IDLE: begin
                if (w_accept && cfg.cfg_en) begin
                    w_div_cur_d = w_div_clamped;
                    w_cnt_d     = '0;
                    w_clk_out_d = 1'b1;
                    w_state_d   = c_RUN;
                end
            end

            c_RUN: begin
                // A request landing on the wrap edge is only queued; this wrap reloads the old ratio.
                w_cnt_d     = w_cnt_next;
                w_clk_out_d = (w_cnt_next < w_half);
                if (w_accept) begin
                    w_en_pend_d  = cfg.cfg_en;
                    w_div_pend_d = w_div_clamped;
                    w_state_d    = c_PEND;
                end
            end

            c_PEND: begin
                if (w_wrap) begin
                    w_cnt_d = '0;
                    if (r_en_pend) begin
                        w_div_cur_d = r_div_pend;
                        w_clk_out_d = 1'b1;
                        w_state_d   = c_RUN;
                    end else begin
                        w_div_cur_d = '0;
                        w_clk_out_d = 1'b0;
                        w_state_d   = c_IDLE;
                    end
                end else begin
                    w_cnt_d     = w_cnt_next;
                    w_clk_out_d = (w_cnt_next < w_half);
                end
            end

            default: w_state_d = c_IDLE;
        endcase
    end

    assign cfg.cfg_ready = (r_state != c_PEND);
    assign cfg.busy      = w_busy;
    assign cfg.tick      = w_wrap;
    assign cfg.clk_out   = r_clk_out;
    assign cfg.div_cur   = r_div_cur;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed scenario bench for clk_div_ctrl.
`default_nettype none

module tb_clk_div_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Observation vector: {clk_out, tick, busy, cfg_ready, div_cur}
  logic [19:0] obs, exp_v;
  logic [7:0]  obs4, exp4;

  clk_div_ctrl_if #(.WIDTH(16)) bus  ();
  clk_div_ctrl_if #(.WIDTH(4))  bus4 ();

  clk_div_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (bus)
  );

  clk_div_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (bus4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic start(input logic [15:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_en    = 1'b1;
    bus.cfg_div   = d;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    obs   = {bus.clk_out, bus.tick, bus.busy, bus.cfg_ready, bus.div_cur};
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", obs, exp_v);
    end
    obs4 = {bus4.clk_out, bus4.tick, bus4.busy, bus4.cfg_ready, bus4.div_cur};
    exp4 = {1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
    n_tests++;
    if (obs4 !== exp4) begin
      n_fail++;
      $display("FAIL reset_state_w4 got=%h exp=%h", obs4, exp4);
    end
    apply_reset();
  endtask

  task automatic test_div4_midreset();
    start(16'd4);
    for (int i = 0; i < 10; i++) begin
      obs   = {bus.clk_out, bus.tick, bus.busy, bus.cfg_ready, bus.div_cur};
      exp_v = {(i % 4) < 2, (i % 4) == 3, 1'b1, 1'b1, 16'd4};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL div4 cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      step();
    end
    // mid-period (cnt=2): asynchronous reset must clear outputs without a clock edge
    #2 rst_n = 1'b0;
    #1;
    obs   = {bus.clk_out, bus.tick, bus.busy, bus.cfg_ready, bus.div_cur};
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL async_reset_midrun got=%h exp=%h", obs, exp_v);
    end
    apply_reset();
  endtask

  task automatic test_odd_clamp();
    apply_reset();
    start(16'd5);
    for (int i = 0; i < 10; i++) begin
      obs   = {bus.clk_out, bus.tick, bus.busy, bus.cfg_ready, bus.div_cur};
      exp_v = {(i % 5) < 2, (i % 5) == 4, 1'b1, 1'b1, 16'd5};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL odd5 cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      start(16'(k));
      for (int i = 0; i < 6; i++) begin
        obs   = {bus.clk_out, bus.tick, bus.busy, bus.cfg_ready, bus.div_cur};
        exp_v = {(i % 2) == 0, (i % 2) == 1, 1'b1, 1'b1, 16'd2};
        n_tests++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL clamp div=%0d cyc=%0d got=%h exp=%h", k, i, obs, exp_v);
        end
        step();
      end
    end
  endtask

  task automatic test_ratio_change();
    int j;
    apply_reset();
    start(16'd6);
    for (int i = 0; i < 12; i++) begin
      obs = {bus.clk_out, bus.tick, bus.busy, bus.cfg_ready, bus.div_cur};
      if (i < 6) begin
        exp_v = {i < 3, i == 5, 1'b1, i < 2, 16'd6};
      end else begin
        j     = i - 6;
        exp_v = {(j % 3) < 1, (j % 3) == 2, 1'b1, 1'b1, 16'd3};
      end
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL ratio_change cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i == 1) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_en    = 1'b1;
        bus.cfg_div   = 16'd3;
      end else if (i == 2) begin
        bus.cfg_valid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_stop_backpressure();
    apply_reset();
    start(16'd8);
    for (int i = 0; i < 10; i++) begin
      obs = {bus.clk_out, bus.tick, bus.busy, bus.cfg_ready, bus.div_cur};
      if (i < 8) exp_v = {i < 4, i == 7, 1'b1, i == 0, 16'd8};
      else       exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL stop_backpressure cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_en    = 1'b0;
        bus.cfg_div   = 16'd8;
      end else if (i == 1) begin
        // held request while queued must be refused
        bus.cfg_en  = 1'b1;
        bus.cfg_div = 16'd5;
      end else if (i == 8) begin
        bus.cfg_valid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_wrap_handshake();
    int j;
    apply_reset();
    start(16'd4);
    for (int i = 0; i < 12; i++) begin
      obs = {bus.clk_out, bus.tick, bus.busy, bus.cfg_ready, bus.div_cur};
      if (i < 8) begin
        exp_v = {(i % 4) < 2, (i % 4) == 3, 1'b1, !(i >= 4), 16'd4};
      end else begin
        j     = i - 8;
        exp_v = {(j % 2) == 0, (j % 2) == 1, 1'b1, 1'b1, 16'd2};
      end
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL wrap_handshake cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i == 3) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_en    = 1'b1;
        bus.cfg_div   = 16'd2;
      end else if (i == 4) begin
        bus.cfg_valid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_max_ratio();
    apply_reset();
    bus4.cfg_valid = 1'b1;
    bus4.cfg_en    = 1'b1;
    bus4.cfg_div   = 4'd15;
    step();
    bus4.cfg_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      obs4 = {bus4.clk_out, bus4.tick, bus4.busy, bus4.cfg_ready, bus4.div_cur};
      exp4 = {(i % 15) < 7, (i % 15) == 14, 1'b1, 1'b1, 4'd15};
      n_tests++;
      if (obs4 !== exp4) begin
        n_fail++;
        $display("FAIL max_ratio cyc=%0d got=%h exp=%h", i, obs4, exp4);
      end
      step();
    end
  endtask

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_en     = 1'b0;
    bus.cfg_div    = 16'd0;
    bus4.cfg_valid = 1'b0;
    bus4.cfg_en    = 1'b0;
    bus4.cfg_div   = 4'd0;
    #2;
    test_reset();
    test_div4_midreset();
    test_odd_clamp();
    test_ratio_change();
    test_stop_backpressure();
    test_wrap_handshake();
    test_max_ratio();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire
